data_memory_lsu: RTL and testbench
==================================

// Module: data_memory_lsu
// PURPOSE
//  RV32 data memory with byte/half/word load-store, byte-lane writes and
//  sign/zero-extended reads. Parametrised depth, registered 1-cycle read,
//  alignment/range error reporting, and an optional post-reset clear
//  sequencer. Sits in the MEM stage between the ALU address path and write-back.
// PARAMETERS
//  DEPTH       256  number of 32-bit words; power of two, >= 4
//  INIT_CLEAR  1    1: zero all words after reset before accepting requests; 0: no clear
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present this cycle
//  req_ready    out  1   block can accept a request (0 during clear)
//  req_we       in   1   1 = store, 0 = load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1   load zero-extend (LBU/LHU); ignored for word and stores
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid    out  1   one-cycle pulse, response for the request accepted last cycle
//  rsp_rdata    out  32  load result, extended; 0 for stores and errors
//  rsp_err      out  1   misaligned, out-of-range, or illegal size
//  init_done    out  1   1 once clear is complete (or immediately if INIT_CLEAR=0)
// BEHAVIOUR
//  - Reset (reset=0, async): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//    init_done=0, clr_ptr=0. State goes to CLEAR if INIT_CLEAR=1, else RUN.
//  - FSM CLEAR: write 0 to word clr_ptr each cycle and increment. After word
//    DEPTH-1 is written (DEPTH cycles) go to RUN; init_done=1 that next cycle.
//    req_ready=0 throughout; requests are ignored. Reset mid-clear restarts at word 0.
//  - FSM RUN: req_ready=1 and init_done=1 permanently. Accept = req_valid & req_ready.
//    One request per cycle, fully pipelined. No response back-pressure.
//  - Error check (at accept): err if req_size=11; or half with addr[0]=1; or word
//    with addr[1:0]!=0; or req_addr >= DEPTH*4. An erroring store writes nothing.
//  - Store: word index addr[log2(DEPTH)+1:2]. SB writes wdata[7:0] to lane addr[1:0].
//    SH writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}. SW writes all 4
//    lanes. Untouched lanes keep their value. Memory is updated at the accept edge.
//  - Load: word read at the accept edge. Lane select follows the store rules.
//    Byte/half is sign-extended, or zero-extended if req_unsigned.
//    Result is registered: rsp_valid=1 on the cycle after accept, then 0 unless
//    another accept occurred. Loads and stores both produce exactly one rsp_valid.
//  - Ordering: a load accepted the cycle after a store to the same word returns
//    the new data. A store has no effect on a response already issued.
//  - rsp_rdata/rsp_err hold their last value while rsp_valid=0. Sample them only
//    when rsp_valid=1.
//  - Reset during RUN drops any pending response. With INIT_CLEAR=0, memory
//    contents are retained. With INIT_CLEAR=1, memory is re-cleared.
// TESTING
//  1 Reset, INIT_CLEAR=1, DEPTH=16: req_ready=0 for 16 cycles, then init_done=1.
//    LW of each of 16 words -> 0x00000000, rsp_err=0.
//  2 SW 0x11223344 @0x8, then LB @0x9 -> 0x00000033; LB @0xB -> 0x00000011;
//    LH @0xA -> 0x00001122.
//  3 SB 0x80 @0x4 on a zeroed word: LB @0x4 -> 0xFFFFFF80; LBU @0x4 -> 0x00000080;
//    LW @0x4 -> 0x00000080.
//  4 SH 0xBEEF @0xE over SW 0xAAAAAAAA @0xC: LW @0xC -> 0xBEEFAAAA;
//    LH @0xE -> 0xFFFFBEEF.
//  5 LW @0x2, SH @0x1, size=11, LW @DEPTH*4: each gives rsp_err=1, rsp_rdata=0,
//    and memory is unchanged.
//  6 Back-to-back SW 0x5 @0x0 then LW @0x0 on consecutive cycles: two rsp_valid
//    pulses; the second returns 0x00000005. Reset asserted mid-stream: no rsp_valid
//    after it.

Source files
------------

// File: rtl/data_memory_lsu.sv
// RV32 data memory for the MEM stage: byte/half/word loads and stores with
// byte-lane writes, sign/zero-extended reads, a registered one-cycle response,
// alignment/range/size error reporting and an optional post-reset clear pass.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_CLEAR | zeroing one word per cycle from clr_ptr_q, requests not accepted
// ST_RUN   | accepting one request per cycle, response the following cycle
module data_memory_lsu #(
   parameter int unsigned DEPTH      = 256,
   parameter bit          INIT_CLEAR = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        init_done_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t        state_q;
   logic [AW-1:0] clr_ptr_q;
   logic          req_ready_q;
   logic          init_done_q;
   logic          rsp_valid_q;
   logic [31:0]   rsp_rdata_q;
   logic          rsp_err_q;

   logic [31:0]   mem_q [DEPTH];

   logic          accept;
   logic          req_err;
   logic          wr_en;
   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic [3:0]    wr_be;
   logic [31:0]   wr_data;
   logic [31:0]   rd_word;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [31:0]   load_val;
   logic [31:0]   rsp_rdata_d;

   assign word_idx = req_addr_i[AW+1:2];
   assign lane     = req_addr_i[1:0];

   // Only the RUN state raises ready, so requests during the clear pass fall on the floor.
   assign accept = req_valid_i & req_ready_q & (state_q == ST_RUN);

   // Any address bit above the word index means the byte address is beyond DEPTH*4.
   always_comb begin
      req_err = 1'b0;
      if (req_size_i == 2'b11)                            req_err = 1'b1;
      if ((req_size_i == SZ_HALF) && req_addr_i[0])       req_err = 1'b1;
      if ((req_size_i == SZ_WORD) && (lane != 2'b00))     req_err = 1'b1;
      if (req_addr_i[31:AW+2] != '0)                      req_err = 1'b1;
   end

   assign wr_en = accept & req_we_i & ~req_err;

   // Store data is right-aligned on the port; replicate it so each enabled lane picks its slice.
   always_comb begin
      wr_be   = 4'b0000;
      wr_data = req_wdata_i;
      case (req_size_i)
         SZ_BYTE: begin
            wr_be   = 4'b0001 << lane;
            wr_data = {4{req_wdata_i[7:0]}};
         end
         SZ_HALF: begin
            wr_be   = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{req_wdata_i[15:0]}};
         end
         SZ_WORD: begin
            wr_be   = 4'b1111;
            wr_data = req_wdata_i;
         end
         default: begin
            wr_be   = 4'b0000;
            wr_data = req_wdata_i;
         end
      endcase
   end

   // Lane select and extension of the addressed word for loads.
   always_comb begin
      rd_word  = mem_q[word_idx];
      rd_byte  = rd_word[{lane, 3'b000} +: 8];
      rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
      load_val = rd_word;
      case (req_size_i)
         SZ_BYTE: load_val = req_unsigned_i ? {24'h000000, rd_byte}
                                            : {{24{rd_byte[7]}}, rd_byte};
         SZ_HALF: load_val = req_unsigned_i ? {16'h0000, rd_half}
                                            : {{16{rd_half[15]}}, rd_half};
         default: load_val = rd_word;
      endcase
   end

   // Stores and failed requests report zero data.
   assign rsp_rdata_d = (req_we_i || req_err) ? 32'h0000_0000 : load_val;

   // Storage array: clear pass or byte-lane store; no reset so contents survive a reset without clear.
   always_ff @(posedge clk_i) begin
      if (state_q == ST_CLEAR) begin
         mem_q[clr_ptr_q] <= 32'h0000_0000;
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Sequencer and registered outputs: clear pass, then run with a one-cycle response pipeline.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= (INIT_CLEAR != 1'b0) ? ST_CLEAR : ST_RUN;
         clr_ptr_q   <= '0;
         req_ready_q <= 1'b0;
         init_done_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               req_ready_q <= 1'b0;
               init_done_q <= 1'b0;
               rsp_valid_q <= 1'b0;
               if (clr_ptr_q == CLR_LAST) begin
                  state_q     <= ST_RUN;
                  clr_ptr_q   <= '0;
                  req_ready_q <= 1'b1;
                  init_done_q <= 1'b1;
               end else begin
                  clr_ptr_q <= clr_ptr_q + 1'b1;
               end
            end
            ST_RUN: begin
               req_ready_q <= 1'b1;
               init_done_q <= 1'b1;
               rsp_valid_q <= accept;
               if (accept) begin
                  rsp_rdata_q <= rsp_rdata_d;
                  rsp_err_q   <= req_err;
               end
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign init_done_o = init_done_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu with DEPTH=16 and the clear pass enabled.
module tb_data_memory_lsu;

   localparam int unsigned DEPTH = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        init_done_o;

   int n_checks = 0;
   int n_errors = 0;

   data_memory_lsu #(.DEPTH(DEPTH), .INIT_CLEAR(1'b1)) u_dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o),
      .init_done_o    (init_done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_size_i     = size;
      req_unsigned_i = uns;
      req_addr_i     = addr;
      req_wdata_i    = wdata;
   endtask

   task automatic idle();
      req_valid_i = 1'b0;
      req_we_i    = 1'b0;
   endtask

   // One request, then check the response pulse on the following cycle.
   task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err);
      @(negedge clk_i);
      drive(we, size, uns, addr, wdata);
      @(negedge clk_i);
      idle();
      check_eq({tag, "_vld"}, {31'b0, rsp_valid_o}, 32'h1);
      check_eq({tag, "_dat"}, rsp_rdata_o, exp_data);
      check_eq({tag, "_err"}, {31'b0, rsp_err_o}, {31'b0, exp_err});
   endtask

   task automatic wait_clear(input string tag);
      int cyc;
      cyc = 0;
      while (!req_ready_o && cyc < 100) begin
         @(posedge clk_i);
         cyc++;
         #1;
      end
      check_eq({tag, "_clr_cycles"}, cyc, DEPTH);
      check_eq({tag, "_init_done"}, {31'b0, init_done_o}, 32'h1);
   endtask

   initial begin
      int pulses;
      rst_ni = 1'b0;
      req_valid_i = 1'b0;
      req_we_i = 1'b0;
      req_size_i = 2'b10;
      req_unsigned_i = 1'b0;
      req_addr_i = '0;
      req_wdata_i = '0;

      repeat (3) @(negedge clk_i);
      check_eq("rst_ready", {31'b0, req_ready_o}, 32'h0);
      check_eq("rst_init_done", {31'b0, init_done_o}, 32'h0);
      check_eq("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
      check_eq("rst_rsp_rdata", rsp_rdata_o, 32'h0);
      check_eq("rst_rsp_err", {31'b0, rsp_err_o}, 32'h0);

      // Requests offered during the clear pass must be ignored.
      rst_ni = 1'b1;
      drive(1'b1, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF);
      wait_clear("t1");
      idle();
      @(negedge clk_i);
      check_eq("t1_no_rsp_in_clear", {31'b0, rsp_valid_o}, 32'h0);

      for (int w = 0; w < DEPTH; w++) begin
         do_req($sformatf("t1_lw%0d", w), 1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0, 32'h0, 1'b0);
      end

      do_req("t2_sw",    1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344, 32'h0, 1'b0);
      do_req("t2_lb9",   1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'h0000_0033, 1'b0);
      do_req("t2_lbB",   1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'h0000_0011, 1'b0);
      do_req("t2_lhA",   1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'h0000_1122, 1'b0);

      do_req("t3_sb",    1'b1, 2'b00, 1'b0, 32'h4, 32'hFFFF_FF80, 32'h0, 1'b0);
      do_req("t3_lb",    1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'hFFFF_FF80, 1'b0);
      do_req("t3_lbu",   1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 32'h0000_0080, 1'b0);
      do_req("t3_lw",    1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0000_0080, 1'b0);

      do_req("t4_sw",    1'b1, 2'b10, 1'b0, 32'hC, 32'hAAAA_AAAA, 32'h0, 1'b0);
      do_req("t4_sh",    1'b1, 2'b01, 1'b0, 32'hE, 32'h1234_BEEF, 32'h0, 1'b0);
      do_req("t4_lw",    1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'hBEEF_AAAA, 1'b0);
      do_req("t4_lh",    1'b0, 2'b01, 1'b0, 32'hE, 32'h0, 32'hFFFF_BEEF, 1'b0);
      do_req("t4_lhu",   1'b0, 2'b01, 1'b1, 32'hC, 32'h0, 32'h0000_AAAA, 1'b0);

      do_req("t5_lw_mis",  1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1);
      do_req("t5_sh_mis",  1'b1, 2'b01, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1);
      do_req("t5_sw_mis",  1'b1, 2'b10, 1'b0, 32'h6, 32'hFFFF_FFFF, 32'h0, 1'b1);
      do_req("t5_sz11_st", 1'b1, 2'b11, 1'b0, 32'h8, 32'hFFFF_FFFF, 32'h0, 1'b1);
      do_req("t5_sz11_ld", 1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1);
      do_req("t5_lw_oor",  1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
      do_req("t5_sw_oor",  1'b1, 2'b10, 1'b0, 32'h40, 32'hFFFF_FFFF, 32'h0, 1'b1);
      do_req("t5_lb_hi",   1'b0, 2'b00, 1'b0, 32'h8000_0008, 32'h0, 32'h0, 1'b1);
      do_req("t5_chk0",    1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
      do_req("t5_chk4",    1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0000_0080, 1'b0);
      do_req("t5_chk8",    1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h1122_3344, 1'b0);

      // Back-to-back store then load of the same word.
      @(negedge clk_i);
      drive(1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_0005);
      @(negedge clk_i);
      check_eq("t6_st_vld", {31'b0, rsp_valid_o}, 32'h1);
      check_eq("t6_st_dat", rsp_rdata_o, 32'h0);
      drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      idle();
      check_eq("t6_ld_vld", {31'b0, rsp_valid_o}, 32'h1);
      check_eq("t6_ld_dat", rsp_rdata_o, 32'h0000_0005);
      check_eq("t6_ld_err", {31'b0, rsp_err_o}, 32'h0);
      @(negedge clk_i);
      check_eq("t6_vld_drop", {31'b0, rsp_valid_o}, 32'h0);

      // Reset right after a load is accepted: its response must vanish and memory re-clears.
      drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      idle();
      #1;
      check_eq("t6_rst_vld", {31'b0, rsp_valid_o}, 32'h0);
      pulses = 0;
      repeat (3) begin
         @(negedge clk_i);
         if (rsp_valid_o) pulses++;
      end
      rst_ni = 1'b1;
      wait_clear("t6");
      repeat (4) begin
         @(negedge clk_i);
         if (rsp_valid_o) pulses++;
      end
      check_eq("t6_no_pulse_after_rst", pulses, 32'h0);
      do_req("t6_recleared8", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
      do_req("t6_recleared0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got 0x%08h expected 0x%08h", 32'h1, 32'h0);
      $fatal(1, "timeout");
   end

endmodule
